// File: rtl/fpu_driver.sv
// fpu_driver: command FIFO plus handshake initiator for the fpu block.
// Upstream commands (operands, op code, tag) are buffered in a small FIFO and
// issued one at a time over the two-phase operand handshake. The result is
// collected over the two-phase result handshake and returned with its tag.
// A watchdog bounds the time spent in ISSUE+WAIT_RESULT. On expiry it returns
// an all-ones result with rsp_timeout set.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   cmd_valid/ready, cmd_*  : upstream command channel
//   fpu_input_rdy/ack       : operand handshake, with fpu_data_a/b, fpu_operation
//   fpu_output_rdy/ack      : result handshake, with fpu_result
//   rsp_valid/ready, rsp_*  : downstream response channel (result, tag, timeout)
module fpu_driver #(
    parameter int unsigned bitness        = 32,
    parameter int unsigned fifo_depth     = 4,
    parameter int unsigned tag_width      = 4,
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [bitness-1:0]   cmd_a,
    input  logic [bitness-1:0]   cmd_b,
    input  logic [3:0]           cmd_op,
    input  logic [tag_width-1:0] cmd_tag,
    output logic                 fpu_input_rdy,
    input  logic                 fpu_input_ack,
    output logic [bitness-1:0]   fpu_data_a,
    output logic [bitness-1:0]   fpu_data_b,
    output logic [3:0]           fpu_operation,
    input  logic                 fpu_output_rdy,
    output logic                 fpu_output_ack,
    input  logic [bitness-1:0]   fpu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [bitness-1:0]   rsp_result,
    output logic [tag_width-1:0] rsp_tag,
    output logic                 rsp_timeout
);

    localparam int unsigned ptr_w = $clog2(fifo_depth);
    localparam int unsigned cnt_w = ptr_w + 1;
    localparam int unsigned wd_w  = $clog2(timeout_cycles + 1);
    localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_depth);
    localparam logic [wd_w-1:0]  wd_limit   = wd_w'(timeout_cycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RESULT,
        ACK_RESULT,
        RESPOND
    } state_t;

    // Command FIFO
    logic [bitness-1:0]   mem_a   [fifo_depth];
    logic [bitness-1:0]   mem_b   [fifo_depth];
    logic [3:0]           mem_op  [fifo_depth];
    logic [tag_width-1:0] mem_tag [fifo_depth];
    logic [ptr_w-1:0]     wr_ptr, rd_ptr;
    logic [cnt_w-1:0]     count;
    logic                 full, empty, push, pop;

    assign full      = (count == full_count);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_a[wr_ptr]   <= cmd_a;
            mem_b[wr_ptr]   <= cmd_b;
            mem_op[wr_ptr]  <= cmd_op;
            mem_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Control FSM
    state_t             state, state_n;
    logic [wd_w-1:0]    wd, wd_n;
    logic               in_rdy_n, out_ack_n, rsp_valid_n, rsp_timeout_n;
    logic [bitness-1:0] rsp_result_n;
    logic               expired;

    assign expired = (wd == wd_limit);

    always_comb begin
        state_n       = state;
        wd_n          = wd;
        in_rdy_n      = fpu_input_rdy;
        out_ack_n     = fpu_output_ack;
        rsp_valid_n   = rsp_valid;
        rsp_timeout_n = rsp_timeout;
        rsp_result_n  = rsp_result;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    in_rdy_n = 1'b1;
                    wd_n     = '0;
                    state_n  = ISSUE;
                end
            end
            ISSUE: begin
                wd_n = wd + 1'b1;
                // The exit condition is tested first, so it wins over a coinciding expiry.
                if (fpu_input_ack) begin
                    in_rdy_n = 1'b0;
                    state_n  = WAIT_RESULT;
                end else if (expired) begin
                    in_rdy_n      = 1'b0;
                    rsp_result_n  = '1;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = 1'b1;
                    state_n       = RESPOND;
                end
            end
            WAIT_RESULT: begin
                wd_n = wd + 1'b1;
                if (fpu_output_rdy) begin
                    rsp_result_n = fpu_result;
                    out_ack_n    = 1'b1;
                    state_n      = ACK_RESULT;
                end else if (expired) begin
                    rsp_result_n  = '1;
                    rsp_timeout_n = 1'b1;
                    rsp_valid_n   = 1'b1;
                    state_n       = RESPOND;
                end
            end
            ACK_RESULT: begin
                if (!fpu_output_rdy) begin
                    out_ack_n     = 1'b0;
                    rsp_valid_n   = 1'b1;
                    rsp_timeout_n = 1'b0;
                    state_n       = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            wd             <= '0;
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
            fpu_data_a     <= '0;
            fpu_data_b     <= '0;
            fpu_operation  <= '0;
            rsp_valid      <= 1'b0;
            rsp_timeout    <= 1'b0;
            rsp_result     <= '0;
            rsp_tag        <= '0;
        end else begin
            state          <= state_n;
            wd             <= wd_n;
            fpu_input_rdy  <= in_rdy_n;
            fpu_output_ack <= out_ack_n;
            rsp_valid      <= rsp_valid_n;
            rsp_timeout    <= rsp_timeout_n;
            rsp_result     <= rsp_result_n;
            if (pop) begin
                fpu_data_a    <= mem_a[rd_ptr];
                fpu_data_b    <= mem_b[rd_ptr];
                fpu_operation <= mem_op[rd_ptr];
                rsp_tag       <= mem_tag[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_fpu_driver.sv
// Self-checking bench for fpu_driver: a behavioural FPU with programmable
// handshake delays, and a scoreboard of expected responses.
module tb_fpu_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_op, cmd_tag;
    logic        fpu_input_rdy, fpu_input_ack;
    logic [31:0] fpu_data_a, fpu_data_b;
    logic [3:0]  fpu_operation;
    logic        fpu_output_rdy, fpu_output_ack;
    logic [31:0] fpu_result;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_timeout;

    always #5 clock = ~clock;

    fpu_driver #(
        .bitness(32),
        .fifo_depth(4),
        .tag_width(4),
        .timeout_cycles(16)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .fpu_input_rdy(fpu_input_rdy), .fpu_input_ack(fpu_input_ack),
        .fpu_data_a(fpu_data_a), .fpu_data_b(fpu_data_b), .fpu_operation(fpu_operation),
        .fpu_output_rdy(fpu_output_rdy), .fpu_output_ack(fpu_output_ack),
        .fpu_result(fpu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
    );

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] result;
        logic        timeout;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Bench FPU arithmetic: the 1.5 + 2.25 case yields 3.75, anything else a fixed mix.
    function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
        if (op == 4'd0 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
    endfunction

    // Behavioural FPU, acting 2 time units after each rising edge.
    int          ack_delay    = 0;
    int          rdy_hold     = 0;
    logic        fpu_stall    = 1'b0;
    logic        result_stall = 1'b0;
    int          phase        = 0;
    int          mcnt         = 0;
    logic [31:0] la, lb;
    logic [3:0]  lop;

    task automatic raise_result;
        fpu_output_rdy = 1'b1;
        fpu_result     = fpu_func(la, lb, lop);
        mcnt           = rdy_hold;
        phase          = 3;
    endtask

    initial begin : fpu_model
        fpu_input_ack  = 1'b0;
        fpu_output_rdy = 1'b0;
        fpu_result     = '0;
        forever begin
            @(posedge clock);
            #2;
            if (reset) begin
                fpu_input_ack  = 1'b0;
                fpu_output_rdy = 1'b0;
                phase          = 0;
            end else begin
                case (phase)
                    0: if (fpu_input_rdy && !fpu_stall) begin
                        la  = fpu_data_a;
                        lb  = fpu_data_b;
                        lop = fpu_operation;
                        if (ack_delay == 0) begin
                            fpu_input_ack = 1'b1;
                            phase = 2;
                        end else begin
                            mcnt  = ack_delay;
                            phase = 1;
                        end
                    end
                    1: begin
                        check("issue_a_stable", fpu_data_a, la);
                        check("issue_b_stable", fpu_data_b, lb);
                        check("issue_rdy_op_stable", {fpu_input_rdy, fpu_operation}, {1'b1, lop});
                        mcnt--;
                        if (mcnt == 0) begin
                            fpu_input_ack = 1'b1;
                            phase = 2;
                        end
                    end
                    2: begin
                        fpu_input_ack = 1'b0;
                        check("input_rdy_dropped", fpu_input_rdy, 0);
                        if (!result_stall) raise_result();
                        else phase = 5;
                    end
                    5: if (!result_stall) raise_result();
                    3: begin
                        check("output_ack_held", fpu_output_ack, 1);
                        if (mcnt == 0) begin
                            fpu_output_rdy = 1'b0;
                            phase = 4;
                        end else begin
                            mcnt--;
                        end
                    end
                    4: begin
                        check("output_ack_dropped", fpu_output_ack, 0);
                        phase = 0;
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    // Edge timing monitor and response collector, sampling on the falling edge.
    logic prev_in = 1'b0, prev_rv = 1'b0, b2b_check = 1'b0;
    int   t_in_rise = 0, t_rsp_rise = 0;

    always @(negedge clock) begin
        if (fpu_input_rdy && !prev_in) begin
            if (b2b_check && t_rsp_rise > t_in_rise) check("b2b_issue_gap", cyc - t_rsp_rise, 2);
            t_in_rise = cyc;
        end
        if (rsp_valid && !prev_rv) t_rsp_rise = cyc;
        prev_in = fpu_input_rdy;
        prev_rv = rsp_valid;
        if (!reset && rsp_valid && rsp_ready) begin
            check("rsp_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("rsp_tag", rsp_tag, e.tag);
                check("rsp_result", rsp_result, e.result);
                check("rsp_timeout", rsp_timeout, e.timeout);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [3:0] tag, input logic to, output int t_acc);
        int k = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && k < 40) begin
            tick();
            k++;
        end
        check("cmd_accept", cmd_ready, 1);
        if (cmd_ready) q.push_back('{tag: tag, result: (to ? 32'hFFFFFFFF : fpu_func(a, b, op)), timeout: to});
        tick();
        t_acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, q.size(), 0);
    endtask

    initial begin : global_limit
        #300000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        int          t_acc;
        int          k;
        logic [31:0] s_res;
        logic [3:0]  s_tag;
        logic        s_to;

        reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        check("reset_ctrl", {fpu_input_rdy, fpu_output_ack, rsp_valid, rsp_timeout, cmd_ready}, 0);
        check("reset_data", {rsp_result, rsp_tag, fpu_operation}, 0);
        reset = 1'b0;
        tick();
        check("cmd_ready_after_reset", cmd_ready, 1);

        // Single add with minimum-latency FPU
        send(32'h3FC00000, 32'h40100000, 4'd0, 4'd5, 1'b0, t_acc);
        drain("drain_single", 40);
        check("accept_to_issue", t_in_rise - t_acc, 1);
        check("issue_to_rsp", t_rsp_rise - t_in_rise, 3);

        // FIFO fill while the FPU withholds ack
        fpu_stall = 1'b1;
        for (int i = 1; i <= 5; i++)
            send(32'h1000_0000 * i + 32'h55, 32'h0A0B_0C00 + i, 4'(i % 4), 4'(i), 1'b0, t_acc);
        check("cmd_ready_full", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_tag = 4'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sixth_held_off", cmd_ready, 0);
        end
        cmd_valid = 1'b0;
        b2b_check = 1'b1;
        fpu_stall = 1'b0;
        drain("drain_fill", 200);
        b2b_check = 1'b0;

        // Slow operand and result handshakes
        ack_delay = 7;
        rdy_hold  = 3;
        send(32'hC0490FDB, 32'h3F800000, 4'd2, 4'd3, 1'b0, t_acc);
        drain("drain_slow", 80);
        ack_delay = 0;
        rdy_hold  = 0;

        // Watchdog expiry, then a normal operation
        fpu_stall = 1'b1;
        send(32'h12345678, 32'h9ABCDEF0, 4'd3, 4'd9, 1'b1, t_acc);
        drain("drain_timeout", 60);
        check("issue_to_timeout", t_rsp_rise - t_in_rise, 16);
        check("rdy_low_after_timeout", fpu_input_rdy, 0);
        fpu_stall = 1'b0;
        send(32'h40000000, 32'h40400000, 4'd1, 4'd10, 1'b0, t_acc);
        drain("drain_after_timeout", 40);

        // Response backpressure
        rsp_ready = 1'b0;
        send(32'h0F0F0F0F, 32'h00FF00FF, 4'd7, 4'd7, 1'b0, t_acc);
        send(32'h11111111, 32'h22222222, 4'd0, 4'd8, 1'b0, t_acc);
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
        check("bp_rsp_valid", rsp_valid, 1);
        s_res = rsp_result; s_tag = rsp_tag; s_to = rsp_timeout;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_rsp_stable", {rsp_valid, rsp_result, rsp_tag, rsp_timeout}, {1'b1, s_res, s_tag, s_to});
            check("bp_no_issue", fpu_input_rdy, 0);
        end
        rsp_ready = 1'b1;
        drain("drain_bp", 60);

        // Reset while waiting for a result with two commands queued
        result_stall = 1'b1;
        send(32'hAAAA0000, 32'h0000BBBB, 4'd0, 4'd11, 1'b0, t_acc);
        send(32'hAAAA0001, 32'h0000BBBC, 4'd1, 4'd12, 1'b0, t_acc);
        send(32'hAAAA0002, 32'h0000BBBD, 4'd2, 4'd13, 1'b0, t_acc);
        k = 0;
        while (phase != 5 && k < 30) begin
            tick();
            k++;
        end
        check("reached_wait_result", phase == 5, 1);
        tick();
        reset = 1'b1;
        tick();
        check("reset_mid_ctrl", {fpu_input_rdy, fpu_output_ack, rsp_valid, rsp_timeout, cmd_ready}, 0);
        check("reset_mid_data", {rsp_result, rsp_tag, fpu_operation}, 0);
        check("reset_mid_operands", {fpu_data_a, fpu_data_b}, 0);
        q.delete();
        reset = 1'b0;
        result_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_quiet", {fpu_input_rdy, rsp_valid}, 0);
        end
        send(32'h3F000000, 32'h3E800000, 4'd0, 4'd14, 1'b0, t_acc);
        drain("drain_after_reset", 40);

        repeat (5) tick();
        check("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
